add_reduce_seq: RTL and testbench



---
 rtl/add_reduce_pkg.sv | 29 ++
 rtl/add_reduce_lane.sv | 29 ++
 rtl/add_reduce_seq.sv | 195 +++++++++++++++++++
 tb/tb_add_reduce_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/add_reduce_pkg.sv
// -----------------------------------------------------------------------------
// add_reduce_pkg
// Shared definitions for the sequential add/max reduction block:
//   state_e   - controller states (the only place the encoding is defined)
//   mode_e    - combine operation selected at start time
//   out_width - result width that holds the sum of n_in unsigned in_w-bit
//               operands without overflow
// -----------------------------------------------------------------------------
package add_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_SUM = 1'b0,
    MODE_MAX = 1'b1
  } mode_e;

  // n_in operands below 2**in_w sum to less than 2**(in_w + clog2(n_in)).
  function automatic int out_width(input int in_w, input int n_in);
    int w;
    w = in_w + $clog2(n_in);
    return (w < in_w) ? in_w : w;
  endfunction

endpackage

// File: rtl/add_reduce_lane.sv
// -----------------------------------------------------------------------------
// add_reduce_lane
// One combinational combine lane: y = a + b in sum mode, max(a, b) in max mode.
// Ports:
//   mode - 0 = sum, 1 = unsigned maximum
//   a, b - OUT_W-bit operands
//   y    - OUT_W-bit combined value
// -----------------------------------------------------------------------------
module add_reduce_lane
  import add_reduce_pkg::*;
#(
  parameter int OUT_W = 13
) (
  input  logic             mode,
  input  logic [OUT_W-1:0] a,
  input  logic [OUT_W-1:0] b,
  output logic [OUT_W-1:0] y
);

  always_comb begin
    if (mode_e'(mode) == MODE_MAX) begin
      y = (a > b) ? a : b;
    end else begin
      // The result width is chosen so that the full reduction cannot wrap.
      y = a + b;
    end
  end

endmodule

// File: rtl/add_reduce_seq.sv
// -----------------------------------------------------------------------------
// add_reduce_seq
// Reduces N_IN unsigned operands to one value (sum or unsigned maximum) over
// several clock cycles, using N_ADD shared two-input combine lanes per cycle.
// Each step pairs the leading values through the lanes and shifts the
// untouched tail down behind them, so the live values always stay packed at
// the bottom of the value register file.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - synchronous active-low reset
//   r_enable  - start strobe; loads operands and mode (also aborts a run)
//   mode      - 0 = sum, 1 = unsigned maximum; sampled with r_enable only
//   init_data - packed operands, operand i at [i*IN_W +: IN_W]
//   busy      - high while a reduction is in progress
//   w_enable  - result valid; held until the next start or reset
//   result    - reduction result
// -----------------------------------------------------------------------------
module add_reduce_seq
  import add_reduce_pkg::*;
#(
  parameter int N_IN  = 7,
  parameter int IN_W  = 10,
  parameter int N_ADD = 2,
  parameter int OUT_W = out_width(IN_W, N_IN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 r_enable,
  input  logic                 mode,
  input  logic [N_IN*IN_W-1:0] init_data,
  output logic                 busy,
  output logic                 w_enable,
  output logic [OUT_W-1:0]     result
);

  localparam int CNT_W = $clog2(N_IN + 1);
  // Lanes beyond this index can never be selected: at most N_IN/2 pairs exist.
  localparam int LANE_LIM = (N_ADD < N_IN) ? N_ADD : N_IN;

  // ---------------------------------------------------------------------------
  // State and value registers
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] live_q, live_d, live_step;
  logic             busy_d, wen_d;
  logic [OUT_W-1:0] result_d;

  logic [OUT_W-1:0] v_q    [N_IN];
  logic [OUT_W-1:0] v_d    [N_IN];
  logic [OUT_W-1:0] step_v [N_IN];
  logic [OUT_W-1:0] lane_out [N_ADD];

  int live_i;
  int k_i;

  // ---------------------------------------------------------------------------
  // Combine lanes: lane g always looks at the pair (v[2g], v[2g+1]).
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N_ADD; g++) begin : g_lane
    logic [OUT_W-1:0] lane_a;
    logic [OUT_W-1:0] lane_b;

    if (2 * g + 1 < N_IN) begin : g_pair
      assign lane_a = v_q[2*g];
      assign lane_b = v_q[2*g+1];
    end else begin : g_none
      assign lane_a = '0;
      assign lane_b = '0;
    end

    add_reduce_lane #(
      .OUT_W (OUT_W)
    ) u_lane (
      .mode (mode_q),
      .a    (lane_a),
      .b    (lane_b),
      .y    (lane_out[g])
    );
  end

  // ---------------------------------------------------------------------------
  // One reduction step: k = min(N_ADD, L/2) pairs combined into v[0..k-1],
  // the unpaired tail v[2k..L-1] moved down to v[k..L-k-1].
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    live_i = int'(live_q);
    k_i    = ((live_i / 2) < N_ADD) ? (live_i / 2) : N_ADD;

    for (int d = 0; d < N_IN; d++) begin
      step_v[d] = v_q[d];
    end

    for (int d = 0; d < LANE_LIM; d++) begin
      if (d < k_i) begin
        step_v[d] = lane_out[d];
      end
    end

    for (int d = 0; d < N_IN; d++) begin
      if ((d >= k_i) && (d < live_i - k_i)) begin
        for (int s = 0; s < N_IN; s++) begin
          if (s == d + k_i) begin
            step_v[d] = v_q[s];
          end
        end
      end
    end

    live_step = CNT_W'(live_i - k_i);
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-register logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    live_d   = live_q;
    busy_d   = busy;
    wen_d    = w_enable;
    result_d = result;
    for (int i = 0; i < N_IN; i++) begin
      v_d[i] = v_q[i];
    end

    if (r_enable) begin
      // A start wins in every state, including an abort of a running reduction.
      for (int i = 0; i < N_IN; i++) begin
        v_d[i] = OUT_W'(init_data[i*IN_W +: IN_W]);
      end
      live_d  = CNT_W'(N_IN);
      mode_d  = mode_e'(mode);
      busy_d  = 1'b1;
      wen_d   = 1'b0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (live_q > CNT_W'(1)) begin
            for (int i = 0; i < N_IN; i++) begin
              v_d[i] = step_v[i];
            end
            live_d = live_step;
          end else begin
            result_d = v_q[0];
            wen_d    = 1'b1;
            busy_d   = 1'b0;
            state_d  = DONE;
          end
        end
        IDLE, DONE: begin
          // Hold everything until the next start.
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          wen_d   = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers (synchronous reset, priority over r_enable)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= MODE_SUM;
      live_q   <= '0;
      busy     <= 1'b0;
      w_enable <= 1'b0;
      result   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      live_q   <= live_d;
      busy     <= busy_d;
      w_enable <= wen_d;
      result   <= result_d;
    end
  end

  // NOTE: the value register file has no reset; its contents are only read
  // after a start has loaded it, so clearing it would add logic for nothing.
  always_ff @(posedge clk) begin
    v_q <= v_d;
  end

endmodule

// File: tb/tb_add_reduce_seq.sv
// -----------------------------------------------------------------------------
// tb_add_reduce_seq
// Three instances share clock and reset:
//   dut 0 - defaults (N_IN=7, N_ADD=2)
//   dut 1 - N_IN=1, N_ADD=1
//   dut 2 - N_IN=8, N_ADD=4
// Expected results and latencies come from a plain arithmetic model of the
// reduction (sum / max over the operand list, step count from the live count).
// -----------------------------------------------------------------------------
module tb_add_reduce_seq;

  localparam int IN_W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [2:0]       re;
  logic [2:0]       md;
  logic [2:0][79:0] data;
  logic [2:0]       busy;
  logic [2:0]       wen;
  logic [12:0]      res0;
  logic [9:0]       res1;
  logic [12:0]      res2;

  add_reduce_seq u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .r_enable  (re[0]),
    .mode      (md[0]),
    .init_data (data[0][69:0]),
    .busy      (busy[0]),
    .w_enable  (wen[0]),
    .result    (res0)
  );

  add_reduce_seq #(.N_IN(1), .IN_W(IN_W), .N_ADD(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .r_enable  (re[1]),
    .mode      (md[1]),
    .init_data (data[1][9:0]),
    .busy      (busy[1]),
    .w_enable  (wen[1]),
    .result    (res1)
  );

  add_reduce_seq #(.N_IN(8), .IN_W(IN_W), .N_ADD(4)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .r_enable  (re[2]),
    .mode      (md[2]),
    .init_data (data[2]),
    .busy      (busy[2]),
    .w_enable  (wen[2]),
    .result    (res2)
  );

  int checks = 0;
  int errors = 0;

  int ops [8];
  int prev_exp [3];
  int n_of [3]   = '{7, 1, 8};
  int nadd_of [3] = '{2, 1, 4};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_res(input int sel);
    case (sel)
      0:       return 32'(res0);
      1:       return 32'(res1);
      default: return 32'(res2);
    endcase
  endfunction

  // Reference model: plain sum or maximum over the operand list.
  function automatic int ref_val(input int n, input bit m);
    int acc = 0;
    for (int i = 0; i < n; i++) begin
      if (m) acc = (ops[i] > acc) ? ops[i] : acc;
      else   acc = acc + ops[i];
    end
    return acc;
  endfunction

  // Reference latency: number of combine steps until one value remains, plus
  // the final edge that publishes the result.
  function automatic int ref_lat(input int n, input int nadd);
    int l = n;
    int r = 0;
    while (l > 1) begin
      l = l - (((l / 2) < nadd) ? (l / 2) : nadd);
      r++;
    end
    return r + 1;
  endfunction

  task automatic set_data(input int sel);
    data[sel] = '0;
    for (int i = 0; i < n_of[sel]; i++) begin
      data[sel][i*IN_W +: IN_W] = ops[i][9:0];
    end
  endtask

  // Drive a one-cycle start strobe; returns #1 after the sampling edge.
  task automatic start(input int sel, input bit m);
    @(negedge clk);
    set_data(sel);
    md[sel] = m;
    re[sel] = 1'b1;
    @(posedge clk);
    #1;
    re[sel] = 1'b0;
    md[sel] = 1'b0;
  endtask

  // Called #1 after the start edge: follow the run to completion.
  task automatic finish_run(input int sel, input bit m, input string tag);
    int exp_v   = ref_val(n_of[sel], m);
    int exp_lat = ref_lat(n_of[sel], nadd_of[sel]);
    int edges   = 0;
    int busy_n  = 0;
    bit held    = 1'b1;
    while (!wen[sel] && edges < 64) begin
      if (busy[sel]) busy_n++;
      if (get_res(sel) !== 32'(prev_exp[sel])) held = 1'b0;
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, " latency"}, 32'(edges), 32'(exp_lat));
    check({tag, " result"}, get_res(sel), 32'(exp_v));
    check({tag, " busy_after"}, 32'(busy[sel]), 32'd0);
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(exp_lat));
    check({tag, " result_held"}, 32'(held), 32'd1);
    prev_exp[sel] = exp_v;
    repeat (2) @(posedge clk);
    #1;
    check({tag, " wen_hold"}, 32'(wen[sel]), 32'd1);
    check({tag, " result_hold"}, get_res(sel), 32'(exp_v));
  endtask

  task automatic do_run(input int sel, input bit m, input string tag);
    start(sel, m);
    finish_run(sel, m, tag);
  endtask

  initial begin
    int wen_seen;
    rst_n = 1'b0;
    re    = '0;
    md    = '0;
    data  = '0;
    prev_exp = '{0, 0, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst busy0", 32'(busy[0]), 32'd0);
    check("rst wen0", 32'(wen[0]), 32'd0);
    check("rst res0", get_res(0), 32'd0);
    check("rst wen1", 32'(wen[1]), 32'd0);
    check("rst wen2", 32'(wen[2]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sum of 1..7
    for (int i = 0; i < 8; i++) ops[i] = i + 1;
    do_run(0, 1'b0, "sum1to7");

    // All-ones operands: widest sum
    for (int i = 0; i < 8; i++) ops[i] = 1023;
    do_run(0, 1'b0, "sum1023");

    // Max mode, then with the maximum removed
    ops[0] = 5; ops[1] = 900; ops[2] = 3; ops[3] = 899;
    ops[4] = 0; ops[5] = 1023; ops[6] = 7;
    do_run(0, 1'b1, "max1023");
    ops[5] = 12;
    do_run(0, 1'b1, "max900");

    // Edge configurations
    ops[0] = 77;
    do_run(1, 1'b0, "n1");
    for (int i = 0; i < 8; i++) ops[i] = i + 1;
    do_run(2, 1'b0, "n8sum");

    // Randomized runs on all three instances
    for (int t = 0; t < 9; t++) begin
      int sel = t % 3;
      bit m   = 1'($urandom % 2);
      for (int i = 0; i < 8; i++) ops[i] = int'($urandom_range(0, 1023));
      do_run(sel, m, $sformatf("rand%0d", t));
    end

    // Abort: restart at edge 2 of a run with all operands 2
    for (int i = 0; i < 8; i++) ops[i] = int'($urandom_range(0, 1023));
    start(0, 1'b1);
    check("abort wen_e0", 32'(wen[0]), 32'd0);
    @(posedge clk);
    #1;
    check("abort wen_e1", 32'(wen[0]), 32'd0);
    for (int i = 0; i < 8; i++) ops[i] = 2;
    start(0, 1'b0);
    finish_run(0, 1'b0, "abort");

    // Reset in the middle of a run
    for (int i = 0; i < 8; i++) ops[i] = int'($urandom_range(1, 1023));
    start(0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst busy", 32'(busy[0]), 32'd0);
    check("midrst wen", 32'(wen[0]), 32'd0);
    check("midrst res", get_res(0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wen_seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (wen[0]) wen_seen++;
    end
    check("midrst no_done", 32'(wen_seen), 32'd0);
    prev_exp = '{0, 0, 0};

    // Reset has priority over a simultaneous start
    @(negedge clk);
    rst_n = 1'b0;
    re[0] = 1'b1;
    @(posedge clk);
    #1;
    check("rstprio busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    re[0] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rstprio idle", 32'(busy[0]), 32'd0);

    // Normal operation after reset
    for (int i = 0; i < 8; i++) ops[i] = i + 1;
    do_run(0, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
